// File: rtl/lu_row_arbiter.sv
// lu_row_arbiter: grants one access per cycle on a single-port row RAM to
// three requesters (LU writeback, LU row read, host loader). Read data comes
// back one cycle after its grant, tagged with the row address it was read from.
// Optional feature: define LU_ARB_AGE_EN to let a starved host or reader
// override the fixed wb > rd > host priority.
module lu_row_arbiter #(
    parameter  int SIZE       = 32,
    parameter  int WIDTH      = 64,
    parameter  int STARVE_MAX = 8,
    localparam int AW         = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int RW         = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    // host row write
    input  logic          host_wr_valid_i,
    output logic          host_wr_ready_o,
    input  logic [AW-1:0] host_wr_addr_i,
    input  logic [RW-1:0] host_wr_data_i,
    // LU row read request / response
    input  logic          rd_req_valid_i,
    output logic          rd_req_ready_o,
    input  logic [AW-1:0] rd_req_addr_i,
    output logic          rd_rsp_valid_o,
    output logic [AW-1:0] rd_rsp_addr_o,
    output logic [RW-1:0] rd_rsp_data_o,
    // LU row writeback
    input  logic          wb_valid_i,
    output logic          wb_ready_o,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [RW-1:0] wb_data_i,
    // RAM port
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [RW-1:0] mem_wdata_o,
    input  logic [RW-1:0] mem_rdata_i,
    output logic          busy_o
);

    localparam int            CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic          rsp_pend_q;
    logic [AW-1:0] rsp_addr_q;
    logic [CW-1:0] rd_wait_q, rd_wait_d;
    logic [CW-1:0] host_wait_q, host_wait_d;
    logic          gnt_wb, gnt_rd, gnt_host;

    // Grant selection; reset and flush suppress every grant so nothing
    // reaches the RAM while the block is being cleared.
    always_comb begin
        gnt_wb   = 1'b0;
        gnt_rd   = 1'b0;
        gnt_host = 1'b0;
        if (rst_ni && !flush_i) begin
`ifdef LU_ARB_AGE_EN
            if (host_wr_valid_i && host_wait_q == SMAX) gnt_host = 1'b1;
            else if (rd_req_valid_i && rd_wait_q == SMAX) gnt_rd = 1'b1;
            else
`endif
            if (wb_valid_i)          gnt_wb   = 1'b1;
            else if (rd_req_valid_i) gnt_rd   = 1'b1;
            else if (host_wr_valid_i) gnt_host = 1'b1;
        end
    end

    assign wb_ready_o      = gnt_wb;
    assign rd_req_ready_o  = gnt_rd;
    assign host_wr_ready_o = gnt_host;

    // RAM port mux; idle outputs park at zero so the port is quiet in reset.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_wb) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wb_addr_i;
            mem_wdata_o = wb_data_i;
        end else if (gnt_rd) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = rd_req_addr_i;
        end else if (gnt_host) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = host_wr_addr_i;
            mem_wdata_o = host_wr_data_i;
        end
    end

    // Wait counters: count cycles spent valid but not granted, saturating.
    always_comb begin
        rd_wait_d   = '0;
        host_wait_d = '0;
        if (!flush_i) begin
            if (rd_req_valid_i && !gnt_rd)
                rd_wait_d = (rd_wait_q == SMAX) ? rd_wait_q : rd_wait_q + 1'b1;
            if (host_wr_valid_i && !gnt_host)
                host_wait_d = (host_wait_q == SMAX) ? host_wait_q : host_wait_q + 1'b1;
        end
    end

    // Read pipeline tag and starvation state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_pend_q  <= 1'b0;
            rsp_addr_q  <= '0;
            rd_wait_q   <= '0;
            host_wait_q <= '0;
        end else begin
            rsp_pend_q  <= gnt_rd;
            if (gnt_rd) rsp_addr_q <= rd_req_addr_i;
            rd_wait_q   <= rd_wait_d;
            host_wait_q <= host_wait_d;
        end
    end

    // RAM read data is passed straight through in the cycle after the grant.
    assign rd_rsp_valid_o = rsp_pend_q;
    assign rd_rsp_addr_o  = rsp_addr_q;
    assign rd_rsp_data_o  = mem_rdata_i;

    assign busy_o = host_wr_valid_i | rd_req_valid_i | wb_valid_i | rsp_pend_q;

endmodule

// File: tb/tb_lu_row_arbiter.sv
// Directed bench for lu_row_arbiter: a grant table plus hand-written
// sequences for load/readback, collision, starvation, flush and mid-read reset.
module tb_lu_row_arbiter;
    localparam int SIZE = 32;
    localparam int WIDTH = 64;
    localparam int AW = 5;
    localparam int RW = SIZE * 2 * WIDTH;

    logic          clk = 1'b0;
    logic          rst_ni, flush_i;
    logic          host_wr_valid_i, host_wr_ready_o;
    logic [AW-1:0] host_wr_addr_i;
    logic [RW-1:0] host_wr_data_i;
    logic          rd_req_valid_i, rd_req_ready_o;
    logic [AW-1:0] rd_req_addr_i;
    logic          rd_rsp_valid_o;
    logic [AW-1:0] rd_rsp_addr_o;
    logic [RW-1:0] rd_rsp_data_o;
    logic          wb_valid_i, wb_ready_o;
    logic [AW-1:0] wb_addr_i;
    logic [RW-1:0] wb_data_i;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [RW-1:0] mem_wdata_o, mem_rdata_i;
    logic          busy_o;

    int nvec = 0;
    int nerr = 0;

    lu_row_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH), .STARVE_MAX(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .host_wr_valid_i(host_wr_valid_i), .host_wr_ready_o(host_wr_ready_o),
        .host_wr_addr_i(host_wr_addr_i), .host_wr_data_i(host_wr_data_i),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_req_addr_i(rd_req_addr_i), .rd_rsp_valid_o(rd_rsp_valid_o),
        .rd_rsp_addr_o(rd_rsp_addr_o), .rd_rsp_data_o(rd_rsp_data_o),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with one-cycle read latency.
    logic [RW-1:0] ram [SIZE];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= ram[mem_addr_o];
        end
    end

    function automatic logic [RW-1:0] rowpat(input logic [31:0] v);
        return {(RW/32){v}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          wb, rd, host, flush;
        logic [2:0]    exp_rdy;   // {wb, rd, host}
        logic          exp_en, exp_we;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl[9];
    int   first;
    logic [RW-1:0] pat;

    initial begin
        // inputs: wb addr 3, rd addr 7, host addr 12
        tbl[0] = '{0,0,0,0, 3'b000, 0,0, 5'd0};
        tbl[1] = '{0,0,1,0, 3'b001, 1,1, 5'd12};
        tbl[2] = '{0,1,0,0, 3'b010, 1,0, 5'd7};
        tbl[3] = '{1,0,0,0, 3'b100, 1,1, 5'd3};
        tbl[4] = '{0,1,1,0, 3'b010, 1,0, 5'd7};
        tbl[5] = '{1,0,1,0, 3'b100, 1,1, 5'd3};
        tbl[6] = '{1,1,1,0, 3'b100, 1,1, 5'd3};
        tbl[7] = '{1,1,1,1, 3'b000, 0,0, 5'd0};
        tbl[8] = '{1,1,0,0, 3'b100, 1,1, 5'd3};

        rst_ni = 1'b0; flush_i = 1'b0;
        host_wr_valid_i = 1'b1; rd_req_valid_i = 1'b1; wb_valid_i = 1'b1;
        host_wr_addr_i = 5'd12; rd_req_addr_i = 5'd7; wb_addr_i = 5'd3;
        host_wr_data_i = rowpat(32'h0000_0c0c); wb_data_i = rowpat(32'h0000_0303);

        // reset with all valids high
        #3;
        chk("rst_readies", {29'd0, wb_ready_o, rd_req_ready_o, host_wr_ready_o}, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_rsp_valid", rd_rsp_valid_o, 0);
        host_wr_valid_i = 1'b0; rd_req_valid_i = 1'b0; wb_valid_i = 1'b0;
        #1;
        chk("rst_idle_busy", busy_o, 0);
        chk("rst_idle_mem", {mem_en_o, mem_we_o, mem_addr_o}, 0);
        chk("rst_idle_rsp_addr", rd_rsp_addr_o, 0);
        // release with all valids high: wb first
        host_wr_valid_i = 1'b1; rd_req_valid_i = 1'b1; wb_valid_i = 1'b1;
        #1 rst_ni = 1'b1;
        #1;
        chk("rel_wb_first", {wb_ready_o, rd_req_ready_o, host_wr_ready_o}, 3'b100);
        host_wr_valid_i = 1'b0; rd_req_valid_i = 1'b0; wb_valid_i = 1'b0;
        tick;

        // grant table
        for (int i = 0; i < 9; i++) begin
            wb_valid_i = tbl[i].wb; rd_req_valid_i = tbl[i].rd;
            host_wr_valid_i = tbl[i].host; flush_i = tbl[i].flush;
            #1;
            chk($sformatf("tbl%0d_rdy", i), {wb_ready_o, rd_req_ready_o, host_wr_ready_o}, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_en", i), mem_en_o, tbl[i].exp_en);
            if (tbl[i].exp_en) begin
                chk($sformatf("tbl%0d_we", i), mem_we_o, tbl[i].exp_we);
                chk($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].exp_addr);
            end
            tick;
        end
        wb_valid_i = 0; rd_req_valid_i = 0; host_wr_valid_i = 0; flush_i = 0;
        tick;

        // host loads rows 0..31
        for (int k = 0; k < SIZE; k++) begin
            host_wr_valid_i = 1'b1; host_wr_addr_i = AW'(k); host_wr_data_i = rowpat(k);
            #1;
            chk($sformatf("load%0d_rdy", k), host_wr_ready_o, 1);
            tick;
        end
        host_wr_valid_i = 1'b0;

        // back-to-back reads 0..31
        for (int k = 0; k <= SIZE; k++) begin
            rd_req_valid_i = (k < SIZE); rd_req_addr_i = AW'(k % SIZE);
            #1;
            if (k < SIZE) chk($sformatf("rd%0d_rdy", k), rd_req_ready_o, 1);
            if (k > 0) begin
                pat = rowpat(k - 1);
                chk($sformatf("rsp%0d_valid", k-1), rd_rsp_valid_o, 1);
                chk($sformatf("rsp%0d_addr", k-1), rd_rsp_addr_o, 64'(k - 1));
                chk($sformatf("rsp%0d_lo", k-1), rd_rsp_data_o[63:0], pat[63:0]);
                chk($sformatf("rsp%0d_hi", k-1), rd_rsp_data_o[RW-1 -: 64], pat[RW-1 -: 64]);
            end
            tick;
        end
        #1 chk("rd_stream_end", rd_rsp_valid_o, 0);
        tick;

        // same-cycle wb/rd collision on row 5
        host_wr_valid_i = 1'b1; host_wr_addr_i = 5'd5; host_wr_data_i = rowpat(32'h1111_1111);
        tick;
        host_wr_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = rowpat(32'haaaa_aaaa);
        rd_req_valid_i = 1'b1; rd_req_addr_i = 5'd5;
        #1;
        chk("coll_t_rdy", {wb_ready_o, rd_req_ready_o, host_wr_ready_o}, 3'b100);
        tick;
        wb_valid_i = 1'b0;
        #1;
        chk("coll_t1_rd_rdy", rd_req_ready_o, 1);
        chk("coll_t1_no_rsp", rd_rsp_valid_o, 0);
        tick;
        rd_req_valid_i = 1'b0;
        #1;
        chk("coll_t2_valid", rd_rsp_valid_o, 1);
        chk("coll_t2_addr", rd_rsp_addr_o, 5);
        chk("coll_t2_data", rd_rsp_data_o[63:0], 64'haaaa_aaaa_aaaa_aaaa);
        tick;

        // starvation: wb held 20 cycles with host valid throughout
        wb_valid_i = 1'b1; wb_addr_i = 5'd20; wb_data_i = rowpat(32'h2020_2020);
        host_wr_valid_i = 1'b1; host_wr_addr_i = 5'd21; host_wr_data_i = rowpat(32'h2121_2121);
        first = 99;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (host_wr_ready_o && first == 99) first = c;
            tick;
        end
`ifdef LU_ARB_AGE_EN
        chk("starve_host_first", 64'(first), 8);
`else
        chk("starve_host_first", 64'(first), 99);
`endif
        wb_valid_i = 1'b0;
        #1;
        chk("starve_host_after_wb", host_wr_ready_o, 1);
        tick;
        host_wr_valid_i = 1'b0;
        tick;

        // flush: response from t still shows in t+1, rd in t+1 blocked
        rd_req_valid_i = 1'b1; rd_req_addr_i = 5'd3;
        #1 chk("flush_t_rdy", rd_req_ready_o, 1);
        tick;
        flush_i = 1'b1; rd_req_addr_i = 5'd4;
        #1;
        chk("flush_rd_blocked", rd_req_ready_o, 0);
        chk("flush_mem_en", mem_en_o, 0);
        chk("flush_rsp_valid", rd_rsp_valid_o, 1);
        chk("flush_rsp_addr", rd_rsp_addr_o, 3);
        chk("flush_rsp_data", rd_rsp_data_o[63:0], 64'h0000_0003_0000_0003);
        tick;
        flush_i = 1'b0; rd_req_valid_i = 1'b0;
        #1;
        chk("flush_t2_no_rsp", rd_rsp_valid_o, 0);
        chk("flush_t2_busy", busy_o, 0);
        tick;

        // reset in the cycle after a rd grant discards the response
        rd_req_valid_i = 1'b1; rd_req_addr_i = 5'd9;
        #1 chk("mrst_rd_rdy", rd_req_ready_o, 1);
        tick;
        rd_req_valid_i = 1'b0; rst_ni = 1'b0;
        #1 chk("mrst_in_rst", rd_rsp_valid_o, 0);
        tick;
        rst_ni = 1'b1;
        #1;
        chk("mrst_rel_rsp", rd_rsp_valid_o, 0);
        chk("mrst_rel_busy", busy_o, 0);
        tick;
        #1 chk("mrst_after_rsp", rd_rsp_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
